multicycle_stage_controller: RTL and testbench

- Multi-cycle sequencer for the single-issue RISC-V core. It generates the per-stage strobes that drive the PC, instruction register, ALU, data memory and the register bank write port (save_to_reg).
- It takes the decoded opcode and rd, and uses ready handshakes to instruction and data memory.
- It sits between the decoder and the datapath and replaces the free-running stage clock with explicit stage enables on one system clock.

---
 rtl/multicycle_stage_controller.sv | 176 +++++++++++++++++
 tb/tb_multicycle_stage_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_stage_controller.sv
// Multi-cycle stage sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK strobes.
// Optional STAGE_TIMEOUT_EN traps after TIMEOUT_CYCLES memory wait cycles.
module multicycle_stage_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic                branch_taken,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_load,
  output logic                alu_en,
  output logic                dmem_req,
  output logic                memwrite,
  output logic                save_to_reg,
  output logic                pc_en,
  output logic                pc_sel,
  output logic [2:0]          state,
  output logic                busy,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t              state_q;
  state_t              state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                legal;
  logic                is_mem;
  logic                is_store;
  logic                is_branch;
  logic                is_jal;
  logic                timeout;

  always_comb begin
    legal     = 1'b1;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LUI: ;
      OP_LOAD:   is_mem    = 1'b1;
      OP_STORE: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OP_BRANCH: is_branch = 1'b1;
      OP_JAL:    is_jal    = 1'b1;
      default:   legal     = 1'b0;
    endcase
  end

`ifdef STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic          waiting;

  // Counter is zero whenever the current state is not stalled on a ready.
  assign waiting = (state_q == FETCH && !imem_ready) ||
                   (state_q == MEM && !dmem_ready);
  assign wait_d  = waiting ? wait_q + 1'b1 : '0;
  assign timeout = waiting && (wait_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    alu_en      = 1'b0;
    dmem_req    = 1'b0;
    memwrite    = 1'b0;
    save_to_reg = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        state_d = legal ? EXECUTE : TRAP;
      end
      EXECUTE: begin
        alu_en = 1'b1;
        if (is_branch) begin
          pc_en   = 1'b1;
          pc_sel  = branch_taken;
          state_d = run ? FETCH : IDLE;
        end else if (is_mem) begin
          state_d = MEM;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        memwrite = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_en   = 1'b1;
            state_d = run ? FETCH : IDLE;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      WRITEBACK: begin
        save_to_reg = (rd != 5'd0);
        pc_en       = 1'b1;
        pc_sel      = is_jal;
        state_d     = run ? FETCH : IDLE;
      end
      TRAP: ;
      default: state_d = IDLE;
    endcase
  end

  // Every retirement is exactly one PC update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_en) retired_q <= retired_q + 1'b1;
    end
  end

  assign state   = state_q;
  assign busy    = (state_q != IDLE);
  assign trap    = (state_q == TRAP);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_stage_controller.sv
// Scoreboard bench for multicycle_stage_controller.
// Stimulus pushes expected retirements / data accesses; monitor pops.
module tb_multicycle_stage_controller;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_load;
  logic        alu_en;
  logic        dmem_req;
  logic        memwrite;
  logic        save_to_reg;
  logic        pc_en;
  logic        pc_sel;
  logic [2:0]  state;
  logic        busy;
  logic        trap;
  logic [31:0] retired;

  multicycle_stage_controller #(
    .TIMEOUT_CYCLES(16),
    .RETIRE_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .opcode(opcode),
    .rd(rd),
    .branch_taken(branch_taken),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_req(imem_req),
    .ir_load(ir_load),
    .alu_en(alu_en),
    .dmem_req(dmem_req),
    .memwrite(memwrite),
    .save_to_reg(save_to_reg),
    .pc_en(pc_en),
    .pc_sel(pc_sel),
    .state(state),
    .busy(busy),
    .trap(trap),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pc_sel;
    bit save;
    int lat;
  } ret_t;

  typedef struct {
    bit memwrite;
    int cycles;
  } mem_t;

  ret_t rq[$];
  mem_t mq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_state(logic [2:0] s, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == s) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_state_%0d actual=%0d required=%0d", s, state, s);
  endtask

  task automatic run_instr(logic [6:0] op, logic [4:0] r, bit bt,
                           int dwait, bit drop_exec,
                           bit e_sel, bit e_save, int e_lat);
    ret_t e;
    mem_t m;
    e.pc_sel = e_sel;
    e.save   = e_save;
    e.lat    = e_lat;
    rq.push_back(e);
    if (op == OP_LOAD || op == OP_STORE) begin
      m.memwrite = (op == OP_STORE);
      m.cycles   = dwait + 1;
      mq.push_back(m);
    end
    opcode       = op;
    rd           = r;
    branch_taken = bt;
    dmem_ready   = (dwait == 0);
    run          = 1'b1;
    wait_state(S_FETCH, 10);
    if (drop_exec) wait_state(S_EXEC, 10);
    run = 1'b0;
    if (dwait > 0) begin
      wait_state(S_MEM, 10);
      repeat (dwait) @(negedge clk);
      dmem_ready = 1'b1;
    end
    wait_state(S_IDLE, 20);
  endtask

  // Monitor
  int         cyc = 0;
  int         fstart = 0;
  int         req_run = 0;
  bit         mw_first;
  logic [2:0] prev_state = S_IDLE;
  int         exp_ret = 0;

  initial begin
    ret_t r;
    mem_t m;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        exp_ret    = 0;
        req_run    = 0;
        prev_state = S_IDLE;
        continue;
      end
      cyc++;
      if (state == S_FETCH && prev_state != S_FETCH) fstart = cyc;
      chk("one_hot_strobes", $countones({save_to_reg, memwrite, ir_load}) <= 1, 1);
      if (save_to_reg) chk("save_with_pc_en", pc_en, 1);
      if (pc_en) begin
        if (rq.size() == 0) begin
          chk("retire_unexpected", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("pc_sel", pc_sel, r.pc_sel);
          chk("save_to_reg", save_to_reg, r.save);
          chk("latency", cyc - fstart + 1, r.lat);
          chk("retired_before", retired, exp_ret);
          exp_ret++;
        end
      end
      if (dmem_req) begin
        req_run++;
        if (req_run == 1) mw_first = memwrite;
        else chk("memwrite_stable", memwrite, mw_first);
        if (dmem_ready) begin
          if (mq.size() == 0) begin
            chk("dmem_unexpected", 1, 0);
          end else begin
            m = mq.pop_front();
            chk("memwrite", memwrite, m.memwrite);
            chk("dmem_req_cycles", req_run, m.cycles);
          end
          req_run = 0;
        end
      end
      prev_state = state;
    end
  end

  initial begin
    int  n;
    bit  bad;
    reset_n      = 1'b0;
    run          = 1'b0;
    opcode       = OP_R;
    rd           = 5'd0;
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    dmem_ready   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", state, S_IDLE);
    chk("rst_strobes", {imem_req, ir_load, alu_en, dmem_req,
                        memwrite, save_to_reg, pc_en}, 0);
    chk("rst_trap", trap, 0);
    chk("rst_retired", retired, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_imem_req", imem_req, 0);

    run_instr(OP_R,      5'd5, 0, 0, 0, 0, 1, 4);
    chk("retired_r", retired, 1);
    run_instr(OP_LOAD,   5'd3, 0, 2, 0, 0, 1, 7);
    run_instr(OP_STORE,  5'd7, 0, 0, 0, 0, 0, 4);
    run_instr(OP_BRANCH, 5'd0, 1, 0, 0, 1, 0, 3);
    run_instr(OP_R,      5'd0, 0, 0, 0, 0, 0, 4);
    chk("retired_5", retired, 5);
    run_instr(OP_JAL,    5'd1, 0, 0, 0, 1, 1, 4);
    run_instr(OP_LUI,    5'd2, 0, 0, 0, 0, 1, 4);
    run_instr(OP_I,      5'd4, 0, 0, 0, 0, 1, 4);
    run_instr(OP_BRANCH, 5'd9, 0, 0, 0, 0, 0, 3);
    run_instr(OP_STORE,  5'd0, 0, 1, 0, 0, 0, 5);

    // run dropped in EXECUTE: writeback still completes
    run_instr(OP_R,      5'd6, 0, 0, 1, 0, 1, 4);
    chk("drop_busy", busy, 0);
    chk("drop_imem_req", imem_req, 0);
    repeat (3) @(negedge clk);
    chk("drop_stays_idle", state, S_IDLE);
    chk("retired_11", retired, 11);

    // illegal opcode
    opcode = OP_BAD;
    run    = 1'b1;
    wait_state(S_FETCH, 10);
    @(negedge clk);
    chk("bad_decode", state, S_DEC);
    @(negedge clk);
    chk("trap_cycle3", state, S_TRAP);
    chk("trap_flag", trap, 1);
    chk("trap_busy", busy, 1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req || alu_en || dmem_req || pc_en || !trap) bad = 1;
    end
    chk("trap_sticky_quiet", bad, 0);
    run     = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("trap_rst_state", state, S_IDLE);
    chk("trap_rst_trap", trap, 0);
    chk("trap_rst_retired", retired, 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef STAGE_TIMEOUT_EN
    opcode     = OP_R;
    imem_ready = 1'b0;
    run        = 1'b1;
    wait_state(S_FETCH, 10);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (state != S_FETCH) break;
      n++;
    end
    chk("timeout_fetch_cycles", n, 16);
    chk("timeout_trap", state, S_TRAP);
    chk("timeout_req_dropped", imem_req, 0);
    run     = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    imem_ready = 1'b1;
`else
    n = 0;
`endif

    repeat (2) @(negedge clk);
    chk("ret_queue_empty", rq.size(), 0);
    chk("mem_queue_empty", mq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
